// File: rtl/pvr_pkg.sv
// Shared object-list definitions: entry encodings, field positions, walker states
// and the primitive-size helper used to step through parameter-buffer arrays.
package pvr_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned MASK_W = 6;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned SKIP_W = 3;
    localparam int unsigned CNT_W  = 5;

    localparam logic [2:0] TYPE_TRI_ARRAY  = 3'b100;
    localparam logic [2:0] TYPE_QUAD_ARRAY = 3'b101;
    localparam logic [2:0] TYPE_INVALID    = 3'b110;
    localparam logic [2:0] TYPE_LINK       = 3'b111;

    localparam int unsigned BIT_STRIP    = 31;
    localparam int unsigned TYPE_HI      = 31;
    localparam int unsigned TYPE_LO      = 29;
    localparam int unsigned MASK_HI      = 30;
    localparam int unsigned CNT_HI       = 28;
    localparam int unsigned CNT_LO       = 25;
    localparam int unsigned SKIP_HI      = 24;
    localparam int unsigned SKIP_LO      = 22;
    localparam int unsigned SHADOW_BIT   = 21;
    localparam int unsigned OFFS_HI      = 20;
    localparam int unsigned LINK_END_BIT = 28;
    localparam int unsigned LINK_HI      = 23;
    localparam int unsigned LINK_LO      = 2;

    localparam int unsigned HDR_WORDS = 3;
    localparam int unsigned VTX_WORDS = 3;

    typedef enum logic [1:0] {
        KIND_STRIP,
        KIND_ARRAY,
        KIND_LINK,
        KIND_INVALID
    } ol_kind_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_STRIP_ISSUE,
        ST_STRIP_WAIT,
        ST_ARRAY_ISSUE,
        ST_ARRAY_WAIT,
        ST_DONE
    } ol_state_e;

    typedef struct packed {
        ol_kind_e          kind;
        logic [MASK_W-1:0] mask;      // mask[i] set = strip triangle i present
        logic [CNT_W-1:0]  count;
        logic [SKIP_W-1:0] skip;
        logic              shadow;
        logic              is_quad;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] link_addr;
        logic              link_end;
    } ol_entry_t;

    // Byte size of one array primitive: header plus nv vertices of (3 + skip) words.
    function automatic logic [ADDR_W-1:0] prim_bytes(input logic is_quad, input logic [SKIP_W-1:0] skip);
        logic [7:0] nv;
        logic [7:0] words;
        nv    = is_quad ? 8'd4 : 8'd3;
        words = 8'(HDR_WORDS) + nv * (8'(VTX_WORDS) + 8'(skip));
        return ADDR_W'({words, 2'b00});
    endfunction

    // Lowest set triangle index in a strip mask (0 when empty).
    function automatic logic [IDX_W-1:0] first_set(input logic [MASK_W-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (m[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ol_entry_decode.sv
// Combinational object-list entry decoder: classifies a fetched word and
// derives its mask, count, skip, shadow, parameter base and link target.
module ol_entry_decode
    import pvr_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [ADDR_W-1:0] param_base,
    output ol_entry_t         entry_c
);

    always_comb begin
        entry_c = '0;
        // Bit 30 is triangle 0, so the mask is stored bit-reversed.
        for (int i = 0; i < MASK_W; i++) begin
            entry_c.mask[i] = word[MASK_HI - i];
        end
        entry_c.count     = CNT_W'(word[CNT_HI:CNT_LO]) + CNT_W'(1);
        entry_c.skip      = word[SKIP_HI:SKIP_LO];
        entry_c.shadow    = word[SHADOW_BIT];
        entry_c.is_quad   = word[TYPE_LO];
        entry_c.base      = param_base + ADDR_W'({word[OFFS_HI:0], 2'b00});
        entry_c.link_addr = ADDR_W'({word[LINK_HI:LINK_LO], 2'b00});
        entry_c.link_end  = word[LINK_END_BIT];

        if (!word[BIT_STRIP]) begin
            entry_c.kind = KIND_STRIP;
        end else begin
            case (word[TYPE_HI:TYPE_LO])
                TYPE_TRI_ARRAY, TYPE_QUAD_ARRAY: entry_c.kind = KIND_ARRAY;
                TYPE_LINK:                       entry_c.kind = KIND_LINK;
                default:                         entry_c.kind = KIND_INVALID;
            endcase
        end
    end

endmodule

// File: rtl/ol_walker.sv
// Object-list walker: follows one tile's object-list chain in VRAM and issues
// one render_poly command per primitive to isp_parser, waiting for poly_drawn.
module ol_walker
    import pvr_pkg::*;
#(
    parameter int unsigned MAX_ENTRIES = 1024
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] ol_base,
    input  logic [ADDR_W-1:0] param_base,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic              ol_vram_rd,
    output logic [ADDR_W-1:0] ol_vram_addr,
    input  logic [WORD_W-1:0] ol_vram_din,
    input  logic              ol_vram_ack,
    output logic [ADDR_W-1:0] poly_addr,
    output logic [IDX_W-1:0]  strip_idx,
    output logic              is_quad,
    output logic              shadow,
    output logic              render_poly,
    input  logic              poly_drawn
);

    localparam int unsigned FCNT_W = $clog2(MAX_ENTRIES + 1);

    ol_state_e         state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0] pbase_q, pbase_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d, fcnt_inc;
    logic [MASK_W-1:0] mask_q, mask_d, mask_rem;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [ADDR_W-1:0] vaddr_d, poly_addr_d, pa_step;
    logic [IDX_W-1:0]  strip_idx_d;
    logic              busy_d, done_d, overrun_d, rd_d, render_d, is_quad_d, shadow_d;
    logic              go_next, go_done;
    ol_entry_t         entry_c;

    ol_entry_decode u_decode (
        .word       (word_q),
        .param_base (pbase_q),
        .entry_c    (entry_c)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        pbase_d     = pbase_q;
        fcnt_d      = fcnt_q;
        mask_d      = mask_q;
        n_d         = n_q;
        skip_d      = skip_q;
        busy_d      = busy;
        done_d      = 1'b0;
        overrun_d   = overrun;
        rd_d        = ol_vram_rd;
        vaddr_d     = ol_vram_addr;
        poly_addr_d = poly_addr;
        strip_idx_d = strip_idx;
        is_quad_d   = is_quad;
        shadow_d    = shadow;
        render_d    = 1'b0;
        go_next     = 1'b0;
        go_done     = 1'b0;
        fcnt_inc    = fcnt_q + FCNT_W'(1);
        mask_rem    = mask_q & ~(MASK_W'(1) << strip_idx);
        pa_step     = poly_addr + prim_bytes(is_quad, skip_q);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d    = 1'b1;
                    overrun_d = 1'b0;
                    vaddr_d   = ol_base;
                    pbase_d   = param_base;
                    fcnt_d    = '0;
                    rd_d      = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (ol_vram_rd && ol_vram_ack) begin
                    rd_d   = 1'b0;
                    word_d = ol_vram_din;
                    fcnt_d = fcnt_inc;
                    if (fcnt_inc == FCNT_W'(MAX_ENTRIES)) begin
                        overrun_d = 1'b1;
                        go_done   = 1'b1;
                    end else begin
                        state_d = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                shadow_d = entry_c.shadow;
                skip_d   = entry_c.skip;
                case (entry_c.kind)
                    KIND_STRIP: begin
                        if (entry_c.mask != '0) begin
                            mask_d      = entry_c.mask;
                            poly_addr_d = entry_c.base;
                            strip_idx_d = first_set(entry_c.mask);
                            is_quad_d   = 1'b0;
                            render_d    = 1'b1;
                            state_d     = ST_STRIP_ISSUE;
                        end else begin
                            go_next = 1'b1;
                        end
                    end
                    KIND_ARRAY: begin
                        n_d         = entry_c.count;
                        poly_addr_d = entry_c.base;
                        strip_idx_d = '0;
                        is_quad_d   = entry_c.is_quad;
                        render_d    = 1'b1;
                        state_d     = ST_ARRAY_ISSUE;
                    end
                    KIND_LINK: begin
                        if (entry_c.link_end) begin
                            go_done = 1'b1;
                        end else begin
                            vaddr_d = entry_c.link_addr;
                            rd_d    = 1'b1;
                            state_d = ST_FETCH;
                        end
                    end
                    default: go_next = 1'b1;
                endcase
            end
            ST_STRIP_ISSUE: state_d = ST_STRIP_WAIT;
            ST_STRIP_WAIT: begin
                if (poly_drawn) begin
                    mask_d = mask_rem;
                    if (mask_rem != '0) begin
                        strip_idx_d = first_set(mask_rem);
                        render_d    = 1'b1;
                        state_d     = ST_STRIP_ISSUE;
                    end else begin
                        go_next = 1'b1;
                    end
                end
            end
            ST_ARRAY_ISSUE: state_d = ST_ARRAY_WAIT;
            ST_ARRAY_WAIT: begin
                if (poly_drawn) begin
                    poly_addr_d = pa_step;
                    n_d         = n_q - CNT_W'(1);
                    if (n_q == CNT_W'(1)) begin
                        go_next = 1'b1;
                    end else begin
                        render_d = 1'b1;
                        state_d  = ST_ARRAY_ISSUE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Advance to the following list word.
        if (go_next) begin
            vaddr_d = ol_vram_addr + ADDR_W'(4);
            rd_d    = 1'b1;
            state_d = ST_FETCH;
        end
        if (go_done) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
        end
    end

    // State and output registers; synchronous reset abandons any walk in flight.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            word_q       <= '0;
            pbase_q      <= '0;
            fcnt_q       <= '0;
            mask_q       <= '0;
            n_q          <= '0;
            skip_q       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
            ol_vram_rd   <= 1'b0;
            ol_vram_addr <= '0;
            poly_addr    <= '0;
            strip_idx    <= '0;
            is_quad      <= 1'b0;
            shadow       <= 1'b0;
            render_poly  <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            pbase_q      <= pbase_d;
            fcnt_q       <= fcnt_d;
            mask_q       <= mask_d;
            n_q          <= n_d;
            skip_q       <= skip_d;
            busy         <= busy_d;
            done         <= done_d;
            overrun      <= overrun_d;
            ol_vram_rd   <= rd_d;
            ol_vram_addr <= vaddr_d;
            poly_addr    <= poly_addr_d;
            strip_idx    <= strip_idx_d;
            is_quad      <= is_quad_d;
            shadow       <= shadow_d;
            render_poly  <= render_d;
        end
    end

endmodule

// File: tb/tb_ol_walker.sv
// Directed bench for ol_walker with a VRAM responder and an isp_parser stand-in.
module tb_ol_walker;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [23:0] ol_base, param_base;
    logic        busy, done, overrun;
    logic        ol_vram_rd;
    logic [23:0] ol_vram_addr;
    logic [31:0] ol_vram_din = '0;
    logic        ol_vram_ack = 1'b0;
    logic [23:0] poly_addr;
    logic [2:0]  strip_idx;
    logic        is_quad, shadow, render_poly;
    logic        poly_drawn = 1'b0;

    always #5 clock = ~clock;

    ol_walker #(.MAX_ENTRIES(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .ol_base      (ol_base),
        .param_base   (param_base),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun),
        .ol_vram_rd   (ol_vram_rd),
        .ol_vram_addr (ol_vram_addr),
        .ol_vram_din  (ol_vram_din),
        .ol_vram_ack  (ol_vram_ack),
        .poly_addr    (poly_addr),
        .strip_idx    (strip_idx),
        .is_quad      (is_quad),
        .shadow       (shadow),
        .render_poly  (render_poly),
        .poly_drawn   (poly_drawn)
    );

    logic [31:0] mem [int];
    logic [23:0] r_addr [$];
    logic [2:0]  r_idx  [$];
    logic        r_quad [$];
    logic        r_sh   [$];
    int          r_cyc  [$];
    logic [23:0] f_addr [$];
    int          f_cyc  [$];
    int          cyc = 0;
    int          n_done = 0;
    int          lat = 0;
    int          pend_cnt = 0;
    logic        pend = 1'b0;
    logic        hold_drawn = 1'b0;
    int          n_chk = 0;
    int          n_pass = 0;

    function automatic logic [31:0] mem_rd(input logic [23:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 32'hF000_0000;
    endfunction

    // VRAM: data one cycle after the request is seen, then ack for one cycle.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        ol_vram_ack <= 1'b0;
        if (ol_vram_rd === 1'b1 && !ol_vram_ack) begin
            if (lat == 1) begin
                ol_vram_ack <= 1'b1;
                ol_vram_din <= mem_rd(ol_vram_addr);
                lat <= 0;
            end else begin
                lat <= lat + 1;
            end
        end else begin
            lat <= 0;
        end
        if (ol_vram_rd === 1'b1 && ol_vram_ack) begin
            f_addr.push_back(ol_vram_addr);
            f_cyc.push_back(cyc);
        end
        if (done === 1'b1) n_done <= n_done + 1;
    end

    // Parser stand-in: logs each render_poly and answers poly_drawn a few cycles later.
    always @(posedge clock) begin
        poly_drawn <= 1'b0;
        if (reset_n !== 1'b1) begin
            pend <= 1'b0;
        end else if (render_poly === 1'b1) begin
            r_addr.push_back(poly_addr);
            r_idx.push_back(strip_idx);
            r_quad.push_back(is_quad);
            r_sh.push_back(shadow);
            r_cyc.push_back(cyc);
            pend     <= 1'b1;
            pend_cnt <= 2;
        end else if (pend && !hold_drawn) begin
            if (pend_cnt == 0) begin
                poly_drawn <= 1'b1;
                pend       <= 1'b0;
            end else begin
                pend_cnt <= pend_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic pulse_start(input logic [23:0] base, input logic [23:0] pb);
        @(negedge clock);
        ol_base = base; param_base = pb; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("busy_on_start", 32'(busy), 32'd1);
        chk("overrun_clr_on_start", 32'(overrun), 32'd0);
    endtask

    task automatic walk(input logic [23:0] base, input logic [23:0] pb);
        int d0;
        int waited;
        d0 = n_done;
        pulse_start(base, pb);
        waited = 0;
        while (n_done == d0 && waited < 500) begin
            @(negedge clock);
            waited++;
        end
        chk("walk_done_pulses", 32'(n_done - d0), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int r0, f0, d0, waited;
        reset_n = 1'b0; start = 1'b0; ol_base = '0; param_base = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_rd", 32'(ol_vram_rd), 32'd0);
        chk("rst_render", 32'(render_poly), 32'd0);
        chk("rst_vram_addr", 32'(ol_vram_addr), 32'd0);
        chk("rst_poly_addr", 32'(poly_addr), 32'd0);
        chk("rst_strip_idx", 32'(strip_idx), 32'd0);
        chk("rst_flags", {30'd0, is_quad, shadow}, 32'd0);
        reset_n = 1'b1;

        // Full strip: six triangles at one base.
        mem.delete();
        mem[32'h1000] = 32'h7E00_0010;
        mem[32'h1004] = 32'hF000_0000;
        r0 = r_addr.size(); f0 = f_addr.size();
        walk(24'h1000, 24'h010000);
        chk("strip_count", 32'(r_addr.size() - r0), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk("strip_addr", 32'(r_addr[r0 + i]), 32'h10040);
            chk("strip_idx", 32'(r_idx[r0 + i]), 32'(i));
            chk("strip_quad", 32'(r_quad[r0 + i]), 32'd0);
        end
        chk("decode_to_render", 32'(r_cyc[r0] - f_cyc[f0]), 32'd2);
        chk("strip_overrun", 32'(overrun), 32'd0);

        // Mask gaps, then a shadowed single-triangle strip.
        mem.delete();
        mem[32'h1000] = 32'h2200_0010;
        mem[32'h1004] = 32'h0220_0004;
        mem[32'h1008] = 32'hF000_0000;
        r0 = r_addr.size();
        walk(24'h1000, 24'h010000);
        chk("gap_count", 32'(r_addr.size() - r0), 32'd3);
        chk("gap_idx0", 32'(r_idx[r0]), 32'd1);
        chk("gap_idx1", 32'(r_idx[r0 + 1]), 32'd5);
        chk("gap_addr1", 32'(r_addr[r0 + 1]), 32'h10040);
        chk("gap_sh1", 32'(r_sh[r0 + 1]), 32'd0);
        chk("shadow_addr", 32'(r_addr[r0 + 2]), 32'h10010);
        chk("shadow_idx", 32'(r_idx[r0 + 2]), 32'd5);
        chk("shadow_bit", 32'(r_sh[r0 + 2]), 32'd1);

        // Quad array, count 2, skip 1.
        mem.delete();
        mem[32'h1000] = 32'hA240_0020;
        mem[32'h1004] = 32'hF000_0000;
        r0 = r_addr.size();
        walk(24'h1000, 24'h010000);
        chk("quad_count", 32'(r_addr.size() - r0), 32'd2);
        chk("quad_addr0", 32'(r_addr[r0]), 32'h10080);
        chk("quad_addr1", 32'(r_addr[r0 + 1]), 32'h100CC);
        chk("quad_flag0", 32'(r_quad[r0]), 32'd1);
        chk("quad_flag1", 32'(r_quad[r0 + 1]), 32'd1);
        chk("quad_idx", 32'(r_idx[r0 + 1]), 32'd0);

        // Triangle array whose parameter addresses wrap past 24 bits.
        mem.delete();
        mem[32'h1000] = 32'h8200_0008;
        r0 = r_addr.size();
        walk(24'h1000, 24'hFFFFF0);
        chk("tri_count", 32'(r_addr.size() - r0), 32'd2);
        chk("tri_addr0_wrap", 32'(r_addr[r0]), 32'h000010);
        chk("tri_addr1", 32'(r_addr[r0 + 1]), 32'h000040);
        chk("tri_quad", 32'(r_quad[r0]), 32'd0);

        // Link, invalid entry skipped, terminator.
        mem.delete();
        mem[32'h1000] = 32'hE000_2000;
        mem[32'h2000] = 32'hC000_0000;
        mem[32'h2004] = 32'hF000_0000;
        r0 = r_addr.size(); f0 = f_addr.size();
        walk(24'h1000, 24'h010000);
        chk("link_renders", 32'(r_addr.size() - r0), 32'd0);
        chk("link_fetches", 32'(f_addr.size() - f0), 32'd3);
        chk("link_fetch0", 32'(f_addr[f0]), 32'h1000);
        chk("link_fetch1", 32'(f_addr[f0 + 1]), 32'h2000);
        chk("link_fetch2", 32'(f_addr[f0 + 2]), 32'h2004);

        // Self-looping link trips the runaway guard after four words.
        mem.delete();
        mem[32'h3000] = 32'hE000_3000;
        f0 = f_addr.size();
        walk(24'h3000, 24'h010000);
        chk("overrun_set", 32'(overrun), 32'd1);
        chk("overrun_fetches", 32'(f_addr.size() - f0), 32'd4);

        // Overrun clears on the next accepted start (checked in pulse_start).
        mem.delete();
        mem[32'h1000] = 32'h7E00_0010;
        mem[32'h1004] = 32'hF000_0000;
        walk(24'h1000, 24'h010000);
        chk("overrun_stays_clear", 32'(overrun), 32'd0);

        // Reset while waiting on the parser.
        hold_drawn = 1'b1;
        r0 = r_addr.size();
        pulse_start(24'h1000, 24'h010000);
        waited = 0;
        while (r_addr.size() == r0 && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        chk("hold_render_seen", 32'(r_addr.size() - r0), 32'd1);
        repeat (2) @(negedge clock);
        d0 = n_done;
        reset_n = 1'b0;
        @(negedge clock);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_render", 32'(render_poly), 32'd0);
        chk("midrst_rd", 32'(ol_vram_rd), 32'd0);
        reset_n = 1'b1;
        hold_drawn = 1'b0;
        repeat (10) @(negedge clock);
        chk("midrst_no_done", 32'(n_done - d0), 32'd0);
        r0 = r_addr.size();
        walk(24'h1000, 24'h010000);
        chk("post_rst_count", 32'(r_addr.size() - r0), 32'd6);
        chk("post_rst_last_idx", 32'(r_idx[r0 + 5]), 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
